retire_sb: RTL and testbench
============================

// Module: retire_sb
// PURPOSE
// Last pipeline stage with a parametrised tag width and a posted store buffer.
// Validates each instruction tag against the internal retire tag, then:
// - writes back to the register bank,
// - closes branch loops (optional predictor-correction mode),
// - raises exceptions, MRET and interrupt acknowledges,
// - counts retired instructions.
// Non-killed stores enter an SB_DEPTH FIFO that drains to data memory over a req/gnt handshake.
// Loads see buffered stores through byte-merge forwarding.
// PARAMETERS
// TAG_WIDTH      3   width of tag_i / current_retire_tag_o; the tag wraps modulo 2**TAG_WIDTH
// SB_DEPTH       4   store-buffer entries; power of two, >=2
// BRANCH_PRED    0   1: jump_o only on misprediction (predicted_branch_i used); 0: jump_o = jump_i
// PORTS
// clk                     in   1          clock
// reset                   in   1          synchronous, active-high
// pc_i                    in   32         PC of the retiring instruction
// results_i               in   32x2       [0]=ALU/store data, [1]=address/jump target
// tag_i                   in   TAG_WIDTH  instruction tag
// mem_write_enable_i      in   4          store byte enables (0 = not a store)
// write_enable_i          in   1          regbank write request
// jump_i                  in   1          branch resolved taken
// predicted_branch_i      in   1          predictor said taken (ignored if BRANCH_PRED=0)
// instruction_operation_i in   iType_e    decoded operation
// exc_ilegal_inst_i, exc_misaligned_fetch_i, exc_inst_access_fault_i  in 1 each  exception flags
// interrupt_pending_i     in   1          interrupt waiting
// mem_data_i              in   32         load data read by execute (word-aligned)
// mem_gnt_i               in   1          memory accepts the head store this cycle
// stall_o                 out  1          retire held: store arrived with buffer full
// killed_o                out  1          tag mismatch
// regbank_write_enable_o  out  1          register-bank write enable
// regbank_data_o          out  32         write-back data
// jump_o, jump_target_o   out  1, 32      redirect request and target to fetch
// mem_write_req_o         out  1          head store valid
// mem_write_address_o, mem_data_o, mem_write_enable_o  out 32,32,4  head store
// sb_empty_o              out  1          buffer empty (used by fences/CSR sync)
// current_retire_tag_o    out  TAG_WIDTH  current retire tag
// raise_exception_o, exception_code_o, machine_return_o, interrupt_ack_o  out  privileged control
// instret_o               out  64         retired-instruction count
// BEHAVIOUR
// - Reset: curr_tag=0, buffer empty (count=0, pointers 0; pending stores discarded), instret=0.
//   After reset all outputs read 0 / NE, except sb_empty_o=1 and killed_o, which is combinational.
// - Retire is accepted when: killed_o=(tag_i!=curr_tag) is 0 and stall_o is 0.
//   Killed or stalled cycles have no side effects: no regbank write, no jump, no push,
//   no exception/MRET/ack, no tag or instret change.
// - stall_o=1 when a store arrives (!killed, mem_write_enable_i!=0, no exception flag) and count==SB_DEPTH.
//   This holds even if mem_gnt_i pops the head that same cycle.
// - Privileged priority (accepted instructions, combinational):
//   access fault > misaligned fetch > illegal > ECALL > EBREAK > MRET > interrupt_pending_i.
//   An exception blocks the store push and the regbank write.
// - Tag: curr_tag+1 (wraps) on the clock edge after an accepted cycle with jump_o|raise|mret|ack.
// - Jump:
//   - BRANCH_PRED=0: jump_o=jump_i, target=results_i[1].
//   - BRANCH_PRED=1: taken-but-not-predicted -> results_i[1]; predicted-but-not-taken -> pc_i; otherwise 0.
//   - jump_target_o=0 whenever jump_o=0.
// - Store buffer:
//   - Push {addr=results_i[1], data=results_i[0], be} at the tail on an accepted store.
//   - mem_write_req_o=!empty, driving the head entry; outputs are 0 when empty.
//   - Pop on mem_write_req_o&mem_gnt_i.
//   - Push and pop in the same cycle: count unchanged. Pointers wrap mod SB_DEPTH.
// - Load forwarding (LB/LBU/LH/LHU/LW):
//   - Every valid entry with addr[31:2]==results_i[1][31:2] overrides the enabled bytes of mem_data_i.
//   - Entries apply oldest->youngest; the head about to pop is included.
//   - The merged word then gets byte/half extraction by results_i[1][1:0] and sign/zero extension.
// - regbank_data_o: the extended load result for MEMORY_UNIT ops, else results_i[0].
// - instret: +1 per accepted cycle without raise_exception_o (MRET, interrupt-ack cycle count).
//   The count wraps at 2**64.
// TESTING
// - Tag wrap (TAG_WIDTH=3): 8 jumps each with tag==curr -> tag 0..7->0; tag_i=5 while curr=0 -> killed_o=1, nothing written.
// - Store back-pressure (SB_DEPTH=4, mem_gnt_i=0): 5 SW -> stall_o=1 on the 5th;
//   gnt=1 one cycle -> head popped, 5th accepted next cycle, count=4.
// - Forwarding: SB 0xAB@0x103 then SH 0x1234@0x100 buffered, mem_data_i=0 -> LW 0x100 returns 0xAB001234.
// - Forwarding extension: LB 0x103 returns 0xFFFFFFAB.
// - Priority: ECALL with exc_ilegal_inst_i=1 and a store -> code ILLEGAL_INSTRUCTION, no push, instret unchanged, tag+1.
// - BRANCH_PRED=1: predicted=1, jump_i=0, pc_i=0x200 -> jump_o=1, target 0x200.
// - Mid-drain reset: reset with 3 entries -> next cycle sb_empty_o=1, mem_write_req_o=0, instret_o=0.

Source files
------------

// File: rtl/retire_sb.sv
// Retire stage: tag check, write-back, branch redirect, privileged control, instret,
// and a posted store buffer with byte-merge load forwarding.
package retire_sb_pkg;
    typedef enum logic [4:0] {
        NOP, ADD, LUI, LB, LBU, LH, LHU, LW, SB, SH, SW,
        BRANCH, JAL, JALR, ECALL, EBREAK, MRET, CSR
    } iType_e;

    typedef enum logic [3:0] {
        NE, ILLEGAL_INSTRUCTION, MISALIGNED_FETCH, INSTRUCTION_ACCESS_FAULT,
        ECALL_FROM_MACHINE, BREAKPOINT
    } exceptionCode_e;
endpackage

module retire_sb
    import retire_sb_pkg::*;
#(
    parameter int TAG_WIDTH   = 3,
    parameter int SB_DEPTH    = 4,
    parameter int BRANCH_PRED = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          pc_i,
    input  logic [31:0]          results_i [2],
    input  logic [TAG_WIDTH-1:0] tag_i,
    input  logic [3:0]           mem_write_enable_i,
    input  logic                 write_enable_i,
    input  logic                 jump_i,
    input  logic                 predicted_branch_i,
    input  iType_e               instruction_operation_i,
    input  logic                 exc_ilegal_inst_i,
    input  logic                 exc_misaligned_fetch_i,
    input  logic                 exc_inst_access_fault_i,
    input  logic                 interrupt_pending_i,
    input  logic [31:0]          mem_data_i,
    input  logic                 mem_gnt_i,
    output logic                 stall_o,
    output logic                 killed_o,
    output logic                 regbank_write_enable_o,
    output logic [31:0]          regbank_data_o,
    output logic                 jump_o,
    output logic [31:0]          jump_target_o,
    output logic                 mem_write_req_o,
    output logic [31:0]          mem_write_address_o,
    output logic [31:0]          mem_data_o,
    output logic [3:0]           mem_write_enable_o,
    output logic                 sb_empty_o,
    output logic [TAG_WIDTH-1:0] current_retire_tag_o,
    output logic                 raise_exception_o,
    output exceptionCode_e       exception_code_o,
    output logic                 machine_return_o,
    output logic                 interrupt_ack_o,
    output logic [63:0]          instret_o
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [TAG_WIDTH-1:0] curr_tag_q, curr_tag_d;
    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [63:0]          instret_q, instret_d;
    logic [31:0]          sb_addr_q [SB_DEPTH];
    logic [31:0]          sb_addr_d [SB_DEPTH];
    logic [31:0]          sb_data_q [SB_DEPTH];
    logic [31:0]          sb_data_d [SB_DEPTH];
    logic [3:0]           sb_be_q   [SB_DEPTH];
    logic [3:0]           sb_be_d   [SB_DEPTH];

    logic        is_store, exc_cand, accept, push, pop;
    logic [31:0] merged_word;

    function automatic logic [31:0] load_extend(input iType_e op, input logic [31:0] word,
                                                input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (op)
            LB:      r = {{24{b[7]}}, b};
            LBU:     r = {24'b0, b};
            LH:      r = {{16{h[15]}}, h};
            LHU:     r = {16'b0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Acceptance: exceptions never push, so they are exempt from buffer-full stalls.
    always_comb begin
        killed_o = (tag_i != curr_tag_q);
        is_store = (mem_write_enable_i != 4'b0);
        exc_cand = exc_ilegal_inst_i | exc_misaligned_fetch_i | exc_inst_access_fault_i
                 | (instruction_operation_i == ECALL) | (instruction_operation_i == EBREAK);
        stall_o  = !killed_o && is_store && !exc_cand && (count_q == CNT_W'(SB_DEPTH));
        accept   = !killed_o && !stall_o;
    end

    always_comb begin
        raise_exception_o = 1'b0;
        exception_code_o  = NE;
        machine_return_o  = 1'b0;
        interrupt_ack_o   = 1'b0;
        if (accept) begin
            if (exc_inst_access_fault_i) begin
                raise_exception_o = 1'b1;
                exception_code_o  = INSTRUCTION_ACCESS_FAULT;
            end else if (exc_misaligned_fetch_i) begin
                raise_exception_o = 1'b1;
                exception_code_o  = MISALIGNED_FETCH;
            end else if (exc_ilegal_inst_i) begin
                raise_exception_o = 1'b1;
                exception_code_o  = ILLEGAL_INSTRUCTION;
            end else if (instruction_operation_i == ECALL) begin
                raise_exception_o = 1'b1;
                exception_code_o  = ECALL_FROM_MACHINE;
            end else if (instruction_operation_i == EBREAK) begin
                raise_exception_o = 1'b1;
                exception_code_o  = BREAKPOINT;
            end else if (instruction_operation_i == MRET) begin
                machine_return_o = 1'b1;
            end else if (interrupt_pending_i) begin
                interrupt_ack_o = 1'b1;
            end
        end
    end

    always_comb begin
        jump_o        = 1'b0;
        jump_target_o = 32'b0;
        if (accept) begin
            if (BRANCH_PRED == 0) begin
                jump_o        = jump_i;
                jump_target_o = results_i[1];
            end else if (jump_i && !predicted_branch_i) begin
                jump_o        = 1'b1;
                jump_target_o = results_i[1];
            end else if (predicted_branch_i && !jump_i) begin
                jump_o        = 1'b1;
                jump_target_o = pc_i;
            end
        end
        if (!jump_o) begin
            jump_target_o = 32'b0;
        end
    end

    // Forwarding walks the buffer oldest to youngest so later stores win per byte.
    always_comb begin
        logic [PTR_W-1:0] idx;
        merged_word = mem_data_i;
        idx         = head_q;
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (sb_addr_q[idx][31:2] == results_i[1][31:2])) begin
                for (int b = 0; b < 4; b++) begin
                    if (sb_be_q[idx][b]) begin
                        merged_word[8*b +: 8] = sb_data_q[idx][8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        regbank_write_enable_o = accept && write_enable_i && !raise_exception_o;
        case (instruction_operation_i)
            LB, LBU, LH, LHU, LW:
                regbank_data_o = load_extend(instruction_operation_i, merged_word, results_i[1][1:0]);
            default:
                regbank_data_o = results_i[0];
        endcase

        mem_write_req_o     = (count_q != '0);
        sb_empty_o          = !mem_write_req_o;
        mem_write_address_o = mem_write_req_o ? sb_addr_q[head_q] : 32'b0;
        mem_data_o          = mem_write_req_o ? sb_data_q[head_q] : 32'b0;
        mem_write_enable_o  = mem_write_req_o ? sb_be_q[head_q]   : 4'b0;

        current_retire_tag_o = curr_tag_q;
        instret_o            = instret_q;
    end

    always_comb begin
        push      = accept && is_store && !raise_exception_o;
        pop       = mem_write_req_o && mem_gnt_i;
        sb_addr_d = sb_addr_q;
        sb_data_d = sb_data_q;
        sb_be_d   = sb_be_q;
        tail_d    = tail_q;
        head_d    = head_q;
        if (push) begin
            sb_addr_d[tail_q] = results_i[1];
            sb_data_d[tail_q] = results_i[0];
            sb_be_d[tail_q]   = mem_write_enable_i;
            tail_d            = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        curr_tag_d = curr_tag_q;
        if (accept && (jump_o || raise_exception_o || machine_return_o || interrupt_ack_o)) begin
            curr_tag_d = curr_tag_q + TAG_WIDTH'(1);
        end
        instret_d = instret_q;
        if (accept && !raise_exception_o) begin
            instret_d = instret_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            curr_tag_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            instret_q  <= '0;
        end else begin
            curr_tag_q <= curr_tag_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            instret_q  <= instret_d;
        end
    end

    // Buffer payload carries no reset; validity is tracked solely by count_q.
    always_ff @(posedge clk) begin
        sb_addr_q <= sb_addr_d;
        sb_data_q <= sb_data_d;
        sb_be_q   <= sb_be_d;
    end

endmodule

// File: tb/tb_retire_sb.sv
// Scoreboard bench for retire_sb: stimulus queues expected write-backs, jumps, exceptions
// and drained stores; a negedge monitor pops and compares whenever the DUT presents one.
module tb_retire_sb;
    import retire_sb_pkg::*;

    logic           clk = 1'b0;
    logic           reset;
    logic [31:0]    pc;
    logic [31:0]    results [2];
    logic [2:0]     tag;
    logic [3:0]     mem_we;
    logic           we, jmp, pred;
    iType_e         op;
    logic           exc_ill, exc_mis, exc_acc, irq;
    logic [31:0]    mem_rdata;
    logic           gnt;

    logic           stall_o, killed_o, rb_we_o, jump_o, req_o, empty_o;
    logic           raise_o, mret_o, ack_o;
    logic [31:0]    rb_data_o, jtgt_o, waddr_o, wdata_o;
    logic [3:0]     wbe_o;
    logic [2:0]     tag_o;
    exceptionCode_e code_o;
    logic [63:0]    instret_o;

    logic           b_stall, b_killed, b_rb_we, b_jump, b_req, b_empty, b_raise, b_mret, b_ack;
    logic [31:0]    b_rb_data, b_jtgt, b_waddr, b_wdata;
    logic [3:0]     b_wbe;
    logic [2:0]     b_tag;
    exceptionCode_e b_code;
    logic [63:0]    b_instret;

    int             errors = 0;
    int             checks = 0;
    logic           mon_en = 1'b0;
    logic [2:0]     cur_tag = 3'd0;
    logic [31:0]    wb_q [$];
    logic [31:0]    jmp_q [$];
    exceptionCode_e exc_q [$];
    logic [67:0]    st_q [$];

    always #5 clk = ~clk;

    retire_sb #(.TAG_WIDTH(3), .SB_DEPTH(4), .BRANCH_PRED(0)) dut (
        .clk(clk), .reset(reset), .pc_i(pc), .results_i(results), .tag_i(tag),
        .mem_write_enable_i(mem_we), .write_enable_i(we), .jump_i(jmp),
        .predicted_branch_i(pred), .instruction_operation_i(op),
        .exc_ilegal_inst_i(exc_ill), .exc_misaligned_fetch_i(exc_mis),
        .exc_inst_access_fault_i(exc_acc), .interrupt_pending_i(irq),
        .mem_data_i(mem_rdata), .mem_gnt_i(gnt), .stall_o(stall_o), .killed_o(killed_o),
        .regbank_write_enable_o(rb_we_o), .regbank_data_o(rb_data_o), .jump_o(jump_o),
        .jump_target_o(jtgt_o), .mem_write_req_o(req_o), .mem_write_address_o(waddr_o),
        .mem_data_o(wdata_o), .mem_write_enable_o(wbe_o), .sb_empty_o(empty_o),
        .current_retire_tag_o(tag_o), .raise_exception_o(raise_o), .exception_code_o(code_o),
        .machine_return_o(mret_o), .interrupt_ack_o(ack_o), .instret_o(instret_o)
    );

    retire_sb #(.TAG_WIDTH(3), .SB_DEPTH(4), .BRANCH_PRED(1)) dut_bp (
        .clk(clk), .reset(reset), .pc_i(pc), .results_i(results), .tag_i(tag),
        .mem_write_enable_i(mem_we), .write_enable_i(we), .jump_i(jmp),
        .predicted_branch_i(pred), .instruction_operation_i(op),
        .exc_ilegal_inst_i(exc_ill), .exc_misaligned_fetch_i(exc_mis),
        .exc_inst_access_fault_i(exc_acc), .interrupt_pending_i(irq),
        .mem_data_i(mem_rdata), .mem_gnt_i(gnt), .stall_o(b_stall), .killed_o(b_killed),
        .regbank_write_enable_o(b_rb_we), .regbank_data_o(b_rb_data), .jump_o(b_jump),
        .jump_target_o(b_jtgt), .mem_write_req_o(b_req), .mem_write_address_o(b_waddr),
        .mem_data_o(b_wdata), .mem_write_enable_o(b_wbe), .sb_empty_o(b_empty),
        .current_retire_tag_o(b_tag), .raise_exception_o(b_raise), .exception_code_o(b_code),
        .machine_return_o(b_mret), .interrupt_ack_o(b_ack), .instret_o(b_instret)
    );

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every DUT-presented event consumes one expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rb_we_o) begin
                if (wb_q.size() == 0) chk("wb_unexpected", {36'b0, rb_data_o}, 68'hDEAD);
                else chk("wb_data", {36'b0, rb_data_o}, {36'b0, wb_q.pop_front()});
            end
            if (jump_o) begin
                if (jmp_q.size() == 0) chk("jump_unexpected", {36'b0, jtgt_o}, 68'hDEAD);
                else chk("jump_target", {36'b0, jtgt_o}, {36'b0, jmp_q.pop_front()});
            end
            if (raise_o) begin
                if (exc_q.size() == 0) chk("exc_unexpected", {64'b0, code_o}, 68'hDEAD);
                else chk("exc_code", {64'b0, code_o}, {64'b0, exc_q.pop_front()});
            end
            if (req_o && gnt) begin
                if (st_q.size() == 0) chk("store_unexpected", {waddr_o, wdata_o, wbe_o}, 68'hDEAD);
                else chk("store_drain", {waddr_o, wdata_o, wbe_o}, st_q.pop_front());
            end
        end
    end

    task automatic idle();
        op = NOP; tag = cur_tag + 3'd1; mem_we = 4'b0; we = 1'b0; jmp = 1'b0; pred = 1'b0;
        exc_ill = 1'b0; exc_mis = 1'b0; exc_acc = 1'b0; irq = 1'b0;
        pc = 32'b0; results[0] = 32'b0; results[1] = 32'b0; mem_rdata = 32'b0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic commit();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        idle();
        op = (be == 4'hF) ? SW : ((be == 4'b0011 || be == 4'b1100) ? SH : SB);
        tag = cur_tag; results[1] = a; results[0] = d; mem_we = be;
        st_q.push_back({a, d, be});
        settle();
        commit();
    endtask

    task automatic do_load(input iType_e o, input logic [31:0] a, input logic [31:0] md,
                           input logic [31:0] exp);
        idle();
        op = o; tag = cur_tag; results[1] = a; mem_rdata = md; we = 1'b1;
        wb_q.push_back(exp);
        settle();
        commit();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; gnt = 1'b0;
        idle();
        repeat (3) commit();
        reset = 1'b0; mon_en = 1'b1;
        settle();
        chk("rst_killed", killed_o, 1);
        chk("rst_sb_empty", empty_o, 1);
        chk("rst_req", req_o, 0);
        chk("rst_tag", tag_o, 0);
        chk("rst_instret", instret_o, 0);
        chk("rst_ctrl", {rb_we_o, jump_o, raise_o, mret_o, ack_o, stall_o}, 0);
        commit();

        // Tag wrap through eight accepted jumps
        for (int i = 0; i < 8; i++) begin
            idle();
            op = JAL; tag = cur_tag; pc = 32'h100 + 32'(i * 4);
            results[1] = 32'h1000 + 32'(i * 16); results[0] = pc + 32'd4; we = 1'b1; jmp = 1'b1;
            wb_q.push_back(results[0]);
            jmp_q.push_back(results[1]);
            settle();
            chk("tag_before_jump", tag_o, 68'(i));
            commit();
            cur_tag = cur_tag + 3'd1;
        end
        idle(); settle();
        chk("tag_wrapped", tag_o, 0);
        chk("instret_after_jumps", instret_o, 8);
        commit();

        idle(); tag = 3'd5; op = ADD; we = 1'b1; jmp = 1'b1; mem_we = 4'hF; results[0] = 32'h77;
        settle();
        chk("killed_flag", killed_o, 1);
        chk("killed_side_effects", {rb_we_o, jump_o, stall_o}, 0);
        commit();
        idle(); settle();
        chk("killed_tag", tag_o, 0);
        chk("killed_instret", instret_o, 8);
        chk("killed_no_push", empty_o, 1);
        commit();

        // Store back-pressure with the buffer full
        for (int k = 0; k < 4; k++) begin
            idle();
            op = SW; tag = cur_tag; mem_we = 4'hF;
            results[1] = 32'h40 + 32'(k * 4); results[0] = 32'h11111111 * 32'(k + 1);
            st_q.push_back({results[1], results[0], 4'hF});
            settle();
            chk("fill_no_stall", stall_o, 0);
            commit();
        end
        idle(); op = SW; tag = cur_tag; mem_we = 4'hF; results[1] = 32'h50; results[0] = 32'h55555555;
        settle();
        chk("stall_full", stall_o, 1);
        commit();
        gnt = 1'b1;
        settle();
        chk("stall_with_gnt", stall_o, 1);
        commit();
        gnt = 1'b0;
        st_q.push_back({32'h50, 32'h55555555, 4'hF});
        settle();
        chk("fifth_accepted", stall_o, 0);
        commit();
        idle(); op = SW; tag = cur_tag; mem_we = 4'hF; results[1] = 32'h60;
        settle();
        chk("count_is_four", stall_o, 1);
        commit();
        idle(); settle();
        chk("instret_after_stores", instret_o, 13);
        chk("head_valid", req_o, 1);
        commit();
        gnt = 1'b1;
        repeat (4) begin
            settle();
            commit();
        end
        gnt = 1'b0;
        settle();
        chk("drained_empty", empty_o, 1);
        commit();

        // Load forwarding and extension
        do_store(32'h103, 32'hAB000000, 4'b1000);
        do_store(32'h100, 32'h00001234, 4'b0011);
        do_load(LW,  32'h100, 32'h0,        32'hAB001234);
        do_load(LB,  32'h103, 32'h0,        32'hFFFFFFAB);
        do_load(LBU, 32'h103, 32'h0,        32'h000000AB);
        do_load(LH,  32'h102, 32'h0,        32'hFFFFAB00);
        do_load(LHU, 32'h100, 32'hFFFFFFFF, 32'h00001234);
        do_store(32'h100, 32'h000000CD, 4'b0001);
        do_load(LW,  32'h100, 32'h77777777, 32'hAB7712CD);
        do_load(LW,  32'h104, 32'hDEADBEEF, 32'hDEADBEEF);
        gnt = 1'b1;
        do_load(LW,  32'h100, 32'h0,        32'hAB0012CD);
        do_load(LW,  32'h100, 32'h0,        32'h000012CD);
        do_load(LB,  32'h100, 32'h0,        32'hFFFFFFCD);
        gnt = 1'b0;
        idle(); settle();
        chk("fwd_drained", empty_o, 1);
        chk("instret_after_fwd", instret_o, 26);
        commit();

        // Privileged priority
        idle(); op = ECALL; tag = cur_tag; exc_ill = 1'b1; mem_we = 4'hF; we = 1'b1; results[1] = 32'h80;
        exc_q.push_back(ILLEGAL_INSTRUCTION);
        settle();
        chk("exc_blocks_wb", rb_we_o, 0);
        commit();
        cur_tag = cur_tag + 3'd1;
        idle(); settle();
        chk("exc_tag", tag_o, 1);
        chk("exc_instret", instret_o, 26);
        chk("exc_no_push", empty_o, 1);
        commit();
        idle(); op = ECALL; tag = cur_tag; exc_q.push_back(ECALL_FROM_MACHINE);
        settle(); commit(); cur_tag = cur_tag + 3'd1;
        idle(); op = ADD; tag = cur_tag; exc_acc = 1'b1; exc_mis = 1'b1; exc_ill = 1'b1;
        exc_q.push_back(INSTRUCTION_ACCESS_FAULT);
        settle(); commit(); cur_tag = cur_tag + 3'd1;
        idle(); op = EBREAK; tag = cur_tag; exc_mis = 1'b1; exc_q.push_back(MISALIGNED_FETCH);
        settle(); commit(); cur_tag = cur_tag + 3'd1;
        idle(); op = MRET; tag = cur_tag; irq = 1'b1;
        settle();
        chk("mret_over_irq", {mret_o, ack_o}, 2'b10);
        commit(); cur_tag = cur_tag + 3'd1;
        idle(); op = ADD; tag = cur_tag; irq = 1'b1; we = 1'b1; results[0] = 32'h42;
        wb_q.push_back(32'h42);
        settle();
        chk("irq_ack", ack_o, 1);
        commit(); cur_tag = cur_tag + 3'd1;
        idle(); settle();
        chk("priv_tag", tag_o, 6);
        chk("priv_instret", instret_o, 28);
        commit();

        // Predictor-correction mode
        reset = 1'b1; cur_tag = 3'd0; idle();
        repeat (2) commit();
        reset = 1'b0;
        idle(); op = BRANCH; tag = 3'd0; pc = 32'h200; results[1] = 32'h300; pred = 1'b1;
        settle();
        chk("bp_mispredict_nt", {b_jump, b_jtgt}, {1'b1, 32'h200});
        chk("nobp_no_jump", {jump_o, jtgt_o}, 0);
        commit();
        idle(); op = BRANCH; tag = 3'd1; jmp = 1'b1; results[1] = 32'h340;
        settle();
        chk("bp_mispredict_t", {b_jump, b_jtgt}, {1'b1, 32'h340});
        commit();
        idle(); op = BRANCH; tag = 3'd2; jmp = 1'b1; pred = 1'b1; results[1] = 32'h380; pc = 32'h210;
        settle();
        chk("bp_correct", {b_jump, b_jtgt}, 0);
        commit();

        // Reset while stores are pending
        do_store(32'h10, 32'hA, 4'hF);
        do_store(32'h14, 32'hB, 4'hF);
        do_store(32'h18, 32'hC, 4'hF);
        idle(); settle();
        chk("pending_req", {req_o, empty_o}, 2'b10);
        commit();
        reset = 1'b1;
        commit();
        reset = 1'b0;
        st_q.delete();
        settle();
        chk("mid_rst_empty", {empty_o, req_o}, 2'b10);
        chk("mid_rst_instret", instret_o, 0);
        chk("mid_rst_tag", tag_o, 0);
        commit();

        chk("left_wb", 68'(wb_q.size()), 0);
        chk("left_jump", 68'(jmp_q.size()), 0);
        chk("left_exc", 68'(exc_q.size()), 0);
        chk("left_store", 68'(st_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
